// File: rtl/mult_seq_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
// Holds the FSM state encoding and the width helper used to size the step counter.
package mult_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/mult_seq_if.sv
// Request/response bundle between a datapath stage and the multiplier.
// The master issues START with operands; the slave reports BUSY, DONE and RESULT.
interface mult_seq_if #(
  parameter int P = 32
);

  logic           START;
  logic [P-1:0]   A;
  logic [P-1:0]   B;
  logic           BUSY;
  logic           DONE;
  logic [2*P-1:0] RESULT;

  modport master (
    output START, A, B,
    input  BUSY, DONE, RESULT
  );

  modport slave (
    input  START, A, B,
    output BUSY, DONE, RESULT
  );

endinterface

// File: rtl/mult_seq_dp.sv
// Shift-add datapath: multiplicand register, accumulator/multiplier shift register
// and step counter, driven by load/step strobes from the controlling FSM.
module mult_seq_dp
  import mult_pkg::*;
#(
  parameter int P = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_i,
  input  logic           step_i,
  input  logic [P-1:0]   a_i,
  input  logic [P-1:0]   b_i,
  output logic [2*P-1:0] accNext_o,
  output logic           lastStep_o
);

  localparam int CntW = clog2(P);

  logic [P-1:0]   mcand_q, mcand_d;
  logic [2*P-1:0] acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [P:0]     sum;
  logic [2*P-1:0] stepAcc;

  // The low half of acc starts as the multiplier and is consumed one bit per step,
  // while partial products accumulate in the high half; the carry lands in the MSB.
  always_comb begin
    sum = {1'b0, acc_q[2*P-1:P]};
    if (acc_q[0]) begin
      sum = sum + {1'b0, mcand_q};
    end
    stepAcc = {sum, acc_q[P-1:1]};

    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      mcand_d = a_i;
      acc_d   = {{P{1'b0}}, b_i};
      cnt_d   = '0;
    end else if (step_i) begin
      acc_d = stepAcc;
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign accNext_o  = stepAcc;
  assign lastStep_o = (cnt_q == CntW'(P - 1));

endmodule

// File: rtl/mult_seq.sv
// Iterative unsigned multiplier: P RUN cycles of shift-add, then a one-cycle FIN
// state that pulses DONE while the registered RESULT feeds a downstream enable register.
module mult_seq
  import mult_pkg::*;
#(
  parameter int P = 32
) (
  input  logic     CLK,
  input  logic     RST,
  mult_seq_if.slave bus
);

  state_e         state_q, state_d;
  logic [2*P-1:0] result_q, result_d;
  logic           load;
  logic           step;
  logic           busy;
  logic           done;
  logic           lastStep;
  logic [2*P-1:0] accNext;

  mult_seq_dp #(
    .P(P)
  ) u_dp (
    .clk        (CLK),
    .rst        (RST),
    .load_i     (load),
    .step_i     (step),
    .a_i        (bus.A),
    .b_i        (bus.B),
    .accNext_o  (accNext),
    .lastStep_o (lastStep)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

  // RESULT only moves on the last RUN step so it stays stable through FIN and IDLE.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    load     = 1'b0;
    step     = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          load    = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (lastStep) begin
          state_d  = S_FIN;
          result_d = accNext;
        end
      end
      S_FIN: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.BUSY   = busy;
  assign bus.DONE   = done;
  assign bus.RESULT = result_q;

endmodule

// File: tb/tb_mult_seq.sv
// Directed bench for mult_seq: a P=32 instance for latency, corner and protocol cases,
// and a P=8 instance swept with random operands against a plain product.
module tb_mult_seq;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mult_seq_if #(.P(32)) bus32 ();
  mult_seq_if #(.P(8))  bus8 ();

  mult_seq #(.P(32)) dut32 (.CLK(clk), .RST(rst), .bus(bus32.slave));
  mult_seq #(.P(8))  dut8  (.CLK(clk), .RST(rst), .bus(bus8.slave));

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Leaves the bench at the falling edge right after the accepting rising edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus32.START = 1'b1;
    bus32.A     = a;
    bus32.B     = b;
    @(negedge clk);
    bus32.START = 1'b0;
  endtask

  task automatic observe32(input int window, input bit repulse, output int doneCount,
                           output int doneAt, output int busyCount);
    doneCount = 0;
    doneAt    = -1;
    busyCount = 0;
    for (int idx = 0; idx < window; idx++) begin
      if (bus32.DONE === 1'b1) begin
        if (doneCount == 0) doneAt = idx;
        doneCount++;
      end
      if (bus32.BUSY === 1'b1) busyCount++;
      bus32.START = repulse && (idx == 5 || idx == 32);
      @(negedge clk);
    end
    bus32.START = 1'b0;
  endtask

  task automatic runOp8(input logic [7:0] a, input logic [7:0] b);
    int doneAt;
    logic [63:0] expected;
    expected = 64'(a) * 64'(b);
    @(negedge clk);
    bus8.START = 1'b1;
    bus8.A     = a;
    bus8.B     = b;
    @(negedge clk);
    bus8.START = 1'b0;
    doneAt = -1;
    for (int idx = 0; idx < 20 && doneAt < 0; idx++) begin
      if (bus8.DONE === 1'b1) doneAt = idx;
      else @(negedge clk);
    end
    checkOutput("p8Latency", 64'(doneAt), 64'd8);
    checkOutput("p8Result", 64'(bus8.RESULT), expected);
    checkOutput("p8NoX", 64'($isunknown({bus8.BUSY, bus8.DONE, bus8.RESULT})), 64'd0);
  endtask

  initial begin
    int doneCount, doneAt, busyCount;
    int first, second;
    logic [63:0] r1, r2;
    bit holdOk;

    rst = 1'b1;
    bus32.START = 1'b0; bus32.A = '0; bus32.B = '0;
    bus8.START  = 1'b0; bus8.A  = '0; bus8.B  = '0;
    repeat (2) @(negedge clk);
    checkOutput("rstBusy", 64'(bus32.BUSY), 64'd0);
    checkOutput("rstDone", 64'(bus32.DONE), 64'd0);
    checkOutput("rstResult", bus32.RESULT, 64'd0);
    checkOutput("rstResult8", 64'(bus8.RESULT), 64'd0);
    rst = 1'b0;

    $display("[TB] basic product 3*5");
    applyStimulus(32'd3, 32'd5);
    observe32(40, 1'b0, doneCount, doneAt, busyCount);
    checkOutput("basicDoneAt", 64'(doneAt), 64'd32);
    checkOutput("basicDoneCount", 64'(doneCount), 64'd1);
    checkOutput("basicBusyCycles", 64'(busyCount), 64'd33);
    checkOutput("basicResult", bus32.RESULT, 64'd15);

    $display("[TB] zero operand with START re-pulsed in RUN and FIN");
    applyStimulus(32'd0, 32'h1234_5678);
    observe32(80, 1'b1, doneCount, doneAt, busyCount);
    checkOutput("zeroDoneCount", 64'(doneCount), 64'd1);
    checkOutput("zeroBusyCycles", 64'(busyCount), 64'd33);
    checkOutput("zeroResult", bus32.RESULT, 64'd0);

    $display("[TB] maximum operands");
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    observe32(40, 1'b0, doneCount, doneAt, busyCount);
    checkOutput("maxDoneAt", 64'(doneAt), 64'd32);
    checkOutput("maxResult", bus32.RESULT, 64'hFFFF_FFFE_0000_0001);

    $display("[TB] reset during RUN");
    applyStimulus(32'd7, 32'd9);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abortBusy", 64'(bus32.BUSY), 64'd0);
    checkOutput("abortDone", 64'(bus32.DONE), 64'd0);
    checkOutput("abortResult", bus32.RESULT, 64'd0);
    observe32(40, 1'b0, doneCount, doneAt, busyCount);
    checkOutput("abortNoDone", 64'(doneCount), 64'd0);
    checkOutput("abortIdle", 64'(busyCount), 64'd0);
    applyStimulus(32'd7, 32'd9);
    observe32(40, 1'b0, doneCount, doneAt, busyCount);
    checkOutput("retryResult", bus32.RESULT, 64'd63);
    checkOutput("retryDoneAt", 64'(doneAt), 64'd32);

    $display("[TB] back-to-back with START held high");
    @(negedge clk);
    bus32.START = 1'b1;
    bus32.A     = 32'd2;
    bus32.B     = 32'd3;
    @(negedge clk);
    bus32.A = 32'd4;
    first = -1; second = -1; holdOk = 1'b1; r1 = '0; r2 = '0;
    for (int idx = 0; idx < 80; idx++) begin
      if (bus32.DONE === 1'b1) begin
        if (first < 0) begin
          first = idx; r1 = bus32.RESULT;
        end else if (second < 0) begin
          second = idx; r2 = bus32.RESULT;
        end
      end else if (first >= 0 && second < 0 && bus32.RESULT !== 64'd6) begin
        holdOk = 1'b0;
      end
      if (idx == 34) bus32.START = 1'b0;
      @(negedge clk);
    end
    checkOutput("b2bFirstAt", 64'(first), 64'd32);
    checkOutput("b2bSecondAt", 64'(second), 64'd66);
    checkOutput("b2bFirstResult", r1, 64'd6);
    checkOutput("b2bSecondResult", r2, 64'd12);
    checkOutput("b2bHold", 64'(holdOk), 64'd1);

    $display("[TB] P=8 sweep");
    runOp8(8'hFF, 8'hFF);
    runOp8(8'h00, 8'hA5);
    runOp8(8'h80, 8'h02);
    for (int n = 0; n < 1000; n++) begin
      runOp8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
